// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a bounded per-grant hold time and a mandatory
// idle (arbitration) cycle between consecutive grants. All outputs registered.
module rr_hold_arbiter #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N-1:0]         r,
   output logic [N-1:0]         g,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 timeout
);
   localparam int PW = $clog2(N);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t        r_state;
   logic [PW-1:0] r_ptr;
   logic [7:0]    r_cnt;

   logic          w_found;
   logic [PW-1:0] w_win;
   logic [N-1:0]  w_onehot;
   logic [PW-1:0] w_ptr_nxt;
   logic          w_own_req;
   logic          w_hold_hit;
   int            w_idx;

   // First set request at or above r_ptr, wrapping past N-1 back to 0.
   always_comb begin
      w_found  = 1'b0;
      w_win    = '0;
      w_onehot = '0;
      w_idx    = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(r_ptr) + k) % N;
         if (!w_found && r[w_idx]) begin
            w_found         = 1'b1;
            w_win           = PW'(w_idx);
            w_onehot[w_idx] = 1'b1;
         end
      end
   end

   assign w_ptr_nxt  = (w_win == PW'(N-1)) ? '0 : w_win + PW'(1);
   assign w_own_req  = |(r & g);
   assign w_hold_hit = (HOLD_MAX != 0) && (int'(r_cnt) == HOLD_MAX - 1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         g       <= '0;
         owner   <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  g       <= w_onehot;
                  owner   <= w_win;
                  busy    <= 1'b1;
                  r_ptr   <= w_ptr_nxt;
                  r_cnt   <= '0;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!w_own_req || w_hold_hit) begin
                  // Either release path returns to IDLE; only revocation pulses timeout.
                  g       <= '0;
                  owner   <= '0;
                  busy    <= 1'b0;
                  timeout <= w_own_req;
                  r_state <= ST_IDLE;
               end else if (r_cnt != 8'hFF) begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin arbiter with a bounded hold time, sharing one resource among `N` requesters. It supersedes fixed-priority allocation wherever starvation is unacceptable. A grant lasts until its requester drops `r` or the hold limit expires, and at least one idle cycle always separates consecutive grants. It sits between the requesting devices and the shared resource. All outputs are registered.

## Interface
- `N`, default 4: number of requesters, legal range 2..16.
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per grant, legal range 0..255. A value of 0 disables the hold limit.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `r` input N: request vector, level-sensitive, bit i for requester i.
- `g` output N: grant vector, one-hot or zero, registered.
- `owner` output $clog2(N): index of the granted requester; 0 when idle.
- `busy` output 1: high exactly when `g != 0`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine with two states, IDLE and GRANT. Reset puts it in IDLE.
- Reset values: `g`=0, `owner`=0, `busy`=0, `timeout`=0, priority pointer `ptr`=0, hold counter `cnt`=0.
- IDLE, when `r == 0`: remain in IDLE and leave all outputs at 0.
- IDLE, when `r != 0`:
  - Select the first set bit of `r` searching from index `ptr` upward and wrapping past N-1 to 0.
  - Call the selected index w. Set `g = 1<<w` and `owner = w`.
  - Update `ptr` to (w+1) mod N and clear `cnt`.
  - Move to GRANT.
- GRANT, when `r[owner] == 0`: clear `g` and `busy`, move to IDLE. `owner` returns to 0. `timeout` stays 0.
- GRANT, when `r[owner] == 1`, `HOLD_MAX != 0` and `cnt == HOLD_MAX-1`:
  - Clear `g`, assert `timeout` for one cycle, move to IDLE.
  - `ptr` has already advanced past the revoked owner, so any other requester wins the next arbitration.
- GRANT, in all other cases: hold `g` and increment `cnt`, saturating at 255.
- Requests from non-owners during GRANT are ignored. They are re-evaluated in the next IDLE cycle.
- `g` always has at most one bit set.
- `g` never goes directly from one non-zero value to a different non-zero value; an all-zero cycle always intervenes.
- A lone requester that keeps `r` high after a timeout is re-granted after exactly one idle cycle.
- Reset mid-grant: `g`, `busy`, `owner` and `timeout` clear immediately, asynchronously. `ptr` returns to 0, so the first grant after reset goes to the lowest-index requester.

## Timing
- Grant latency: `r` sampled high in IDLE at edge k produces `g` high from edge k onward, i.e. during cycle k+1.
- Release latency: `r[owner]` sampled low at edge k produces `g` low from edge k.
- Hold bound: with `HOLD_MAX = H > 0`, `g` stays high for at most H consecutive cycles.
  - `timeout` is high in the first cycle `g` is low, i.e. the cycle after the H-th grant cycle.
- Minimum gap between grants: 1 cycle. The IDLE cycle is the arbitration cycle.
- `busy` equals `|g` in every cycle, with no skew.
- `owner` is valid whenever `busy` is high, and changes only on the edges where `g` changes.
- `timeout` is never high in the same cycle as `busy`.

## Test plan
- Reset with `r=4'b1111` held: all outputs are 0 while `resetn` is low. After release, the first grant is `g=4'b0001`, `owner=0`, one cycle later.
- All four requesters held high, requests dropped as each grant appears: grant sequence is 0001, 0010, 0100, 1000, 0001, with one zero cycle between each pair.
- `HOLD_MAX=3`, `r=4'b0100` held: `g=0100` for exactly 3 cycles, then `g=0` with `timeout=1` for 1 cycle, then `g=0100` again. The pattern repeats.
- `HOLD_MAX=3`, `r=4'b0110` held: grants alternate 0010, 0100, 0010, each lasting 3 cycles, with a `timeout` pulse after each.
- Owner 1 drops `r[1]` after 2 cycles while `r[3]` is high: `g` goes 0010 then 0000, `timeout=0`, then 1000.
- `HOLD_MAX=0`, `r=4'b0001` held for 300 cycles: `g=0001` throughout with no timeout. Then assert `resetn=0` mid-grant: `g=0` with no clock edge required.
